// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode selectors, flag bundle and a
// constant-foldable clog2 for sizing pointer/count fields.
package fifo_pkg;

    localparam int unsigned MODE_STD  = 0;
    localparam int unsigned MODE_FWFT = 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Smallest r with 2**r >= n; n=1 yields 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_flex: one synchronous write port, one combinational
// read port. Contents are not reset; the pointers decide which entries are valid.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with programmable almost flags, fill count,
// sticky error flags and a standard or first-word-fall-through read port.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PTR_WIDTH  = clog2(DEPTH),
    parameter int unsigned AF_LEVEL   = DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    parameter int unsigned FWFT       = MODE_STD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C     = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] AE_C     = CNT_WIDTH'(AE_LEVEL);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam bit                   IS_FWFT  = (FWFT == MODE_FWFT);
    localparam fifo_flags_t FLAGS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'(AF_LEVEL == 0),
        almost_empty: 1'b1
    };

    if (DEPTH < 2 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
        $error("sync_fifo_flex: illegal DEPTH/AE_LEVEL/AF_LEVEL combination");
    end

    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  head_vld_q, head_vld_d;
    fifo_flags_t           flags_q, flags_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  wr_ok_c;
    logic                  rd_ok_c;
    logic                  pop_mem_c;
    logic [CNT_WIDTH-1:0]  mem_cnt_c;
    logic [DATA_WIDTH-1:0] mem_rdata;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok_c),
        .waddr (wptr_q),
        .wdata (data_in),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    // Next-state: accept decisions, pointer/count update, output register and flags.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        head_vld_d = 1'b0;
        flags_d    = flags_q;
        mem_cnt_c  = count_q;
        pop_mem_c  = 1'b0;

        wr_ok_c = w_en & ~flags_q.full;
        rd_ok_c = r_en & ~flags_q.empty;

        unique case ({wr_ok_c, rd_ok_c})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        if (wr_ok_c) begin
            wptr_d = ptr_inc(wptr_q);
        end

        // FWFT: count covers the output register, memory holds the rest; refill the
        // head whenever it is free or being consumed and memory has a word.
        if (IS_FWFT) begin
            mem_cnt_c     = count_q - CNT_WIDTH'(head_vld_q);
            pop_mem_c     = (mem_cnt_c != '0) & (~head_vld_q | rd_ok_c);
            head_vld_d    = pop_mem_c | (head_vld_q & ~rd_ok_c);
            flags_d.empty = ~head_vld_d;
        end else begin
            pop_mem_c     = rd_ok_c;
            flags_d.empty = (count_d == '0);
        end

        if (pop_mem_c) begin
            rptr_d = ptr_inc(rptr_q);
            dout_d = mem_rdata;
        end

        flags_d.full         = (count_d == DEPTH_C);
        flags_d.almost_full  = (count_d >= AF_C);
        flags_d.almost_empty = (count_d <= AE_C);

        ovf_d = (w_en & flags_q.full)  | (ovf_q & ~clr_err);
        unf_d = (r_en & flags_q.empty) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            head_vld_q <= 1'b0;
            flags_q    <= FLAGS_RST;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            head_vld_q <= head_vld_d;
            flags_q    <= flags_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign data_out     = dout_q;
    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: three instances (standard depth 8, standard depth 6,
// FWFT depth 5) checked against a queue-based reference model.
module tb_sync_fifo_flex;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_en_a [3];
    logic       r_en_a [3];
    logic       clr_a  [3];
    logic [7:0] din_a  [3];
    logic [7:0] dout_w [3];
    logic       full_w [3];
    logic       empty_w[3];
    logic       af_w   [3];
    logic       ae_w   [3];
    logic [3:0] cnt_w  [3];
    logic       ovf_w  [3];
    logic       unf_w  [3];

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance ordered contents plus visible-head state for FWFT.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int         dep [3] = '{8, 6, 5};
    int         afl [3] = '{6, 5, 4};
    int         ael [3] = '{2, 1, 1};
    bit         fw  [3] = '{1'b0, 1'b0, 1'b1};
    bit         sh  [3];
    logic [7:0] edo [3];
    bit         eov [3];
    bit         eun [3];

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std8 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en_a[0]), .data_in(din_a[0]), .r_en(r_en_a[0]),
        .clr_err(clr_a[0]), .data_out(dout_w[0]), .full(full_w[0]), .empty(empty_w[0]),
        .almost_full(af_w[0]), .almost_empty(ae_w[0]), .count(cnt_w[0]),
        .overflow(ovf_w[0]), .underflow(unf_w[0]));

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(0)) u_std6 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en_a[1]), .data_in(din_a[1]), .r_en(r_en_a[1]),
        .clr_err(clr_a[1]), .data_out(dout_w[1]), .full(full_w[1]), .empty(empty_w[1]),
        .almost_full(af_w[1]), .almost_empty(ae_w[1]), .count(cnt_w[1]),
        .overflow(ovf_w[1]), .underflow(unf_w[1]));

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u_fwft5 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en_a[2]), .data_in(din_a[2]), .r_en(r_en_a[2]),
        .clr_err(clr_a[2]), .data_out(dout_w[2]), .full(full_w[2]), .empty(empty_w[2]),
        .almost_full(af_w[2]), .almost_empty(ae_w[2]), .count(cnt_w[2]),
        .overflow(ovf_w[2]), .underflow(unf_w[2]));

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qfront(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(input int i, input logic [7:0] d);
        case (i)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic qpop(input int i, output logic [7:0] d);
        case (i)
            0:       d = q0.pop_front();
            1:       d = q1.pop_front();
            default: d = q2.pop_front();
        endcase
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            w_en_a[i] = 1'b0;
            r_en_a[i] = 1'b0;
            clr_a[i]  = 1'b0;
            din_a[i]  = 8'h00;
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) begin
            sh[i]  = 1'b0;
            edo[i] = 8'h00;
            eov[i] = 1'b0;
            eun[i] = 1'b0;
        end
    endtask

    // Advance the model with the currently driven inputs, then take one clock edge.
    task automatic tick();
        for (int i = 0; i < 3; i++) begin
            int         sz;
            int         unshown;
            bit         fullp;
            bit         emptp;
            bit         wr;
            bit         rd;
            logic [7:0] tmp;
            sz      = qsize(i);
            unshown = sz - (sh[i] ? 1 : 0);
            fullp   = (sz == dep[i]);
            emptp   = fw[i] ? !sh[i] : (sz == 0);
            wr      = w_en_a[i] && !fullp;
            rd      = r_en_a[i] && !emptp;
            eov[i]  = (w_en_a[i] && fullp) || (eov[i] && !clr_a[i]);
            eun[i]  = (r_en_a[i] && emptp) || (eun[i] && !clr_a[i]);
            if (rd) begin
                qpop(i, tmp);
                if (!fw[i]) edo[i] = tmp;
            end
            if (fw[i]) begin
                if (rd) sh[i] = (unshown > 0);
                else if (!sh[i]) sh[i] = (sz > 0);
                if (sh[i]) edo[i] = qfront(i);
            end
            if (wr) qpush(i, din_a[i]);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (cnt_w[i] !== 4'd0) begin errors++; $display("FAIL reset_count inst%0d got %0d exp 0", i, cnt_w[i]); end
            checks++; if (empty_w[i] !== 1'b1) begin errors++; $display("FAIL reset_empty inst%0d got %b exp 1", i, empty_w[i]); end
            checks++; if (full_w[i] !== 1'b0) begin errors++; $display("FAIL reset_full inst%0d got %b exp 0", i, full_w[i]); end
            checks++; if (ae_w[i] !== 1'b1) begin errors++; $display("FAIL reset_ae inst%0d got %b exp 1", i, ae_w[i]); end
            checks++; if (af_w[i] !== 1'b0) begin errors++; $display("FAIL reset_af inst%0d got %b exp 0", i, af_w[i]); end
            checks++; if (dout_w[i] !== 8'h00) begin errors++; $display("FAIL reset_dout inst%0d got %h exp 00", i, dout_w[i]); end
            checks++; if ({ovf_w[i], unf_w[i]} !== 2'b00) begin errors++; $display("FAIL reset_err inst%0d got %b exp 00", i, {ovf_w[i], unf_w[i]}); end
        end
        rst_n = 1'b1;
    endtask

    // Fill depth-8 instance to full, overflow it, drain it, then underflow it.
    task automatic test_fill_overflow();
        for (int k = 1; k <= 8; k++) begin
            w_en_a[0] = 1'b1;
            din_a[0]  = 8'(k);
            tick();
            checks++; if (cnt_w[0] !== 4'(k)) begin errors++; $display("FAIL fill_count k=%0d got %0d exp %0d", k, cnt_w[0], k); end
            checks++; if (ae_w[0] !== (k <= 2)) begin errors++; $display("FAIL fill_ae k=%0d got %b exp %b", k, ae_w[0], (k <= 2)); end
            checks++; if (af_w[0] !== (k >= 6)) begin errors++; $display("FAIL fill_af k=%0d got %b exp %b", k, af_w[0], (k >= 6)); end
            checks++; if (full_w[0] !== (k == 8)) begin errors++; $display("FAIL fill_full k=%0d got %b exp %b", k, full_w[0], (k == 8)); end
        end
        w_en_a[0] = 1'b1;
        din_a[0]  = 8'h99;
        tick();
        checks++; if (cnt_w[0] !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", cnt_w[0]); end
        checks++; if (ovf_w[0] !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf_w[0]); end
        clr_a[0] = 1'b1;
        tick();
        checks++; if (ovf_w[0] !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf_w[0]); end
        for (int k = 1; k <= 8; k++) begin
            r_en_a[0] = 1'b1;
            tick();
            checks++; if (dout_w[0] !== 8'(k)) begin errors++; $display("FAIL drain_data k=%0d got %h exp %h", k, dout_w[0], 8'(k)); end
        end
        checks++; if (empty_w[0] !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty_w[0]); end
        r_en_a[0] = 1'b1;
        tick();
        checks++; if (unf_w[0] !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", unf_w[0]); end
        checks++; if (dout_w[0] !== 8'h08) begin errors++; $display("FAIL unf_hold got %h exp 08", dout_w[0]); end
    endtask

    // Depth-6 instance: 20 interleaved writes/reads wrap the pointers three times.
    task automatic test_wrap();
        logic [7:0] words[20];
        int         rd_idx;
        rd_idx = 0;
        for (int i = 0; i < 20; i++) words[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 20; i++) begin
            w_en_a[1] = 1'b1;
            din_a[1]  = words[i];
            r_en_a[1] = (i >= 2);
            tick();
            if (i >= 2) begin
                checks++; if (dout_w[1] !== words[rd_idx]) begin errors++; $display("FAIL wrap_data idx=%0d got %h exp %h", rd_idx, dout_w[1], words[rd_idx]); end
                rd_idx++;
            end
        end
        while (rd_idx < 20) begin
            r_en_a[1] = 1'b1;
            tick();
            checks++; if (dout_w[1] !== words[rd_idx]) begin errors++; $display("FAIL wrap_data idx=%0d got %h exp %h", rd_idx, dout_w[1], words[rd_idx]); end
            rd_idx++;
        end
        checks++; if (empty_w[1] !== 1'b1 || cnt_w[1] !== 4'd0) begin errors++; $display("FAIL wrap_end got empty=%b count=%0d exp empty=1 count=0", empty_w[1], cnt_w[1]); end
    endtask

    task automatic test_fwft_single();
        w_en_a[2] = 1'b1;
        din_a[2]  = 8'hA5;
        tick();
        checks++; if (cnt_w[2] !== 4'd1) begin errors++; $display("FAIL fwft_count1 got %0d exp 1", cnt_w[2]); end
        checks++; if (empty_w[2] !== 1'b1) begin errors++; $display("FAIL fwft_empty_n got %b exp 1", empty_w[2]); end
        tick();
        checks++; if (empty_w[2] !== 1'b0) begin errors++; $display("FAIL fwft_empty_n1 got %b exp 0", empty_w[2]); end
        checks++; if (dout_w[2] !== 8'hA5) begin errors++; $display("FAIL fwft_data got %h exp a5", dout_w[2]); end
        r_en_a[2] = 1'b1;
        tick();
        checks++; if (empty_w[2] !== 1'b1 || cnt_w[2] !== 4'd0) begin errors++; $display("FAIL fwft_pop got empty=%b count=%0d exp empty=1 count=0", empty_w[2], cnt_w[2]); end
    endtask

    task automatic test_simultaneous();
        clr_a[0] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            w_en_a[0] = 1'b1;
            din_a[0]  = 8'(8'h31 + k);
            tick();
        end
        w_en_a[0] = 1'b1;
        r_en_a[0] = 1'b1;
        din_a[0]  = 8'h34;
        tick();
        checks++; if (cnt_w[0] !== 4'd3) begin errors++; $display("FAIL simul_count got %0d exp 3", cnt_w[0]); end
        checks++; if (dout_w[0] !== 8'h31) begin errors++; $display("FAIL simul_data got %h exp 31", dout_w[0]); end
        for (int k = 0; k < 3; k++) begin
            r_en_a[0] = 1'b1;
            tick();
            checks++; if (dout_w[0] !== 8'(8'h32 + k)) begin errors++; $display("FAIL simul_order k=%0d got %h exp %h", k, dout_w[0], 8'(8'h32 + k)); end
        end
        w_en_a[0] = 1'b1;
        r_en_a[0] = 1'b1;
        din_a[0]  = 8'h55;
        tick();
        checks++; if (cnt_w[0] !== 4'd1) begin errors++; $display("FAIL simul_empty_count got %0d exp 1", cnt_w[0]); end
        checks++; if (unf_w[0] !== 1'b1) begin errors++; $display("FAIL simul_unf got %b exp 1", unf_w[0]); end
        r_en_a[0] = 1'b1;
        tick();
        checks++; if (dout_w[0] !== 8'h55) begin errors++; $display("FAIL simul_last got %h exp 55", dout_w[0]); end
    endtask

    // Random traffic on all three instances, alternating fill-biased and drain-biased phases.
    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int wp;
            int rp;
            wp = ((c / 100) % 2 == 0) ? 70 : 35;
            rp = ((c / 100) % 2 == 0) ? 35 : 70;
            for (int i = 0; i < 3; i++) begin
                w_en_a[i] = ($urandom_range(99) < wp);
                r_en_a[i] = ($urandom_range(99) < rp);
                clr_a[i]  = ($urandom_range(99) < 4);
                din_a[i]  = 8'($urandom);
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                int sz;
                bit exp_empty;
                sz        = qsize(i);
                exp_empty = fw[i] ? !sh[i] : (sz == 0);
                checks++; if (cnt_w[i] !== 4'(sz)) begin errors++; $display("FAIL rnd_count c=%0d inst%0d got %0d exp %0d", c, i, cnt_w[i], sz); end
                checks++; if (empty_w[i] !== exp_empty) begin errors++; $display("FAIL rnd_empty c=%0d inst%0d got %b exp %b", c, i, empty_w[i], exp_empty); end
                checks++; if (full_w[i] !== (sz == dep[i])) begin errors++; $display("FAIL rnd_full c=%0d inst%0d got %b exp %b", c, i, full_w[i], (sz == dep[i])); end
                checks++; if (af_w[i] !== (sz >= afl[i])) begin errors++; $display("FAIL rnd_af c=%0d inst%0d got %b exp %b", c, i, af_w[i], (sz >= afl[i])); end
                checks++; if (ae_w[i] !== (sz <= ael[i])) begin errors++; $display("FAIL rnd_ae c=%0d inst%0d got %b exp %b", c, i, ae_w[i], (sz <= ael[i])); end
                checks++; if (ovf_w[i] !== eov[i] || unf_w[i] !== eun[i]) begin errors++; $display("FAIL rnd_err c=%0d inst%0d got %b%b exp %b%b", c, i, ovf_w[i], unf_w[i], eov[i], eun[i]); end
                if (!fw[i] || sh[i]) begin
                    checks++; if (dout_w[i] !== edo[i]) begin errors++; $display("FAIL rnd_data c=%0d inst%0d got %h exp %h", c, i, dout_w[i], edo[i]); end
                end
            end
        end
    endtask

    // Asynchronous reset in the middle of a write burst at count 5.
    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (q0.size() != 5 && guard < 50) begin
            if (q0.size() < 5) begin
                w_en_a[0] = 1'b1;
                din_a[0]  = 8'($urandom);
            end else begin
                r_en_a[0] = 1'b1;
            end
            tick();
            guard++;
        end
        checks++; if (cnt_w[0] !== 4'd5) begin errors++; $display("FAIL mid_precount got %0d exp 5", cnt_w[0]); end
        w_en_a[0] = 1'b1;
        din_a[0]  = 8'hEE;
        rst_n     = 1'b0;
        #2;
        checks++; if (cnt_w[0] !== 4'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", cnt_w[0]); end
        checks++; if ({empty_w[0], full_w[0], ae_w[0], af_w[0]} !== 4'b1010) begin errors++; $display("FAIL mid_flags got %b exp 1010", {empty_w[0], full_w[0], ae_w[0], af_w[0]}); end
        checks++; if (dout_w[0] !== 8'h00) begin errors++; $display("FAIL mid_dout got %h exp 00", dout_w[0]); end
        checks++; if ({ovf_w[0], unf_w[0]} !== 2'b00) begin errors++; $display("FAIL mid_err got %b exp 00", {ovf_w[0], unf_w[0]}); end
        model_reset();
        clear_inputs();
        rst_n = 1'b1;
        w_en_a[0] = 1'b1;
        din_a[0]  = 8'h77;
        tick();
        r_en_a[0] = 1'b1;
        tick();
        checks++; if (dout_w[0] !== 8'h77) begin errors++; $display("FAIL mid_first got %h exp 77", dout_w[0]); end
        checks++; if (cnt_w[0] !== 4'd0) begin errors++; $display("FAIL mid_after_count got %0d exp 0", cnt_w[0]); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_fwft_single();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
